// File: rtl/stream_ctrl.sv
// Selects the fibonacci or timer stream for the CDC FIFO write port,
// pauses on full, and drains the FIFO on stop before returning to idle.
module stream_ctrl #(
    parameter int DATA_W        = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop_f_t,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_out,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_out,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    output logic              f_en,
    output logic              t_en,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic [2:0]        state,
    output logic [15:0]       word_count,
    output logic [7:0]        drop_count,
    output logic              drain_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMM_F    = 3'd1,
        S_WAIT_F    = 3'd2,
        S_COMM_T    = 3'd3,
        S_WAIT_T    = 3'd4,
        S_BUF_EMPTY = 3'd5
    } state_t;

    localparam int DRAIN_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

    state_t             st;
    logic [DRAIN_W-1:0] drain_cnt;

    logic start_f_q;
    logic start_t_q;
    logic stop_q;
    logic hist_ok;

    logic start_f_edge;
    logic start_t_edge;
    logic stop_edge;
    logic in_f;
    logic in_t;
    logic drop_hit;

    // hist_ok masks the first clock after reset so a held level never fires
    assign start_f_edge = hist_ok & start_f  & ~start_f_q;
    assign start_t_edge = hist_ok & start_t  & ~start_t_q;
    assign stop_edge    = hist_ok & stop_f_t & ~stop_q;

    assign in_f = (st == S_COMM_F) | (st == S_WAIT_F);
    assign in_t = (st == S_COMM_T) | (st == S_WAIT_T);

    assign state     = st;
    assign f_en      = (st == S_COMM_F) & ~buffer_full;
    assign t_en      = (st == S_COMM_T) & ~buffer_full;
    assign data_1_en = ((st == S_COMM_F) & f_valid & ~buffer_full)
                     | ((st == S_COMM_T) & t_valid & ~buffer_full);

    assign drop_hit = ((st == S_COMM_F) & f_valid & buffer_full)
                    | ((st == S_WAIT_F) & f_valid)
                    | ((st == S_COMM_T) & t_valid & buffer_full)
                    | ((st == S_WAIT_T) & t_valid);

    always_comb begin
        data_1 = '0;
        if (in_f)
            data_1 = f_out;
        else if (in_t)
            data_1 = t_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            drain_cnt  <= '0;
            start_f_q  <= 1'b0;
            start_t_q  <= 1'b0;
            stop_q     <= 1'b0;
            hist_ok    <= 1'b0;
            word_count <= '0;
            drop_count <= '0;
            drain_err  <= 1'b0;
        end else begin
            start_f_q <= start_f;
            start_t_q <= start_t;
            stop_q    <= stop_f_t;
            hist_ok   <= 1'b1;

            if (data_1_en)
                word_count <= word_count + 16'd1;
            if (drop_hit && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            unique case (st)
                S_IDLE: begin
                    if (start_f_edge) begin
                        st         <= S_COMM_F;
                        word_count <= '0;
                        drop_count <= '0;
                    end else if (start_t_edge) begin
                        st         <= S_COMM_T;
                        word_count <= '0;
                        drop_count <= '0;
                    end
                end
                S_COMM_F, S_COMM_T: begin
                    if (stop_edge) begin
                        st        <= S_BUF_EMPTY;
                        drain_cnt <= '0;
                    end else if (buffer_full) begin
                        st <= (st == S_COMM_F) ? S_WAIT_F : S_WAIT_T;
                    end
                end
                S_WAIT_F, S_WAIT_T: begin
                    if (stop_edge) begin
                        st        <= S_BUF_EMPTY;
                        drain_cnt <= '0;
                    end else if (!buffer_full) begin
                        st <= (st == S_WAIT_F) ? S_COMM_F : S_COMM_T;
                    end
                end
                S_BUF_EMPTY: begin
                    if (buffer_empty) begin
                        st <= S_IDLE;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        st        <= S_IDLE;
                        drain_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
